// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  CAUSE_NONE     = 2'b00;
  localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  CAUSE_ACCESS   = 2'b10;
  localparam logic [31:0] INSTR_BYTES    = 32'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: redirect load wins over sequential increment, else hold.
module fetch_pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            inc_i,
  input  logic [XLEN-1:0] inc_pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_pc_i;
    else if (inc_i) pc_d = inc_pc_i;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Multicycle RV32 fetch controller: one req/gnt/rvalid read per fetch_start,
// delivering the word with a one-cycle IR write enable or a fault pulse.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            fetch_start,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            ir_we,
  output logic            fetch_busy,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause
);

  fetch_state_e    state_q;
  logic            kill_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic            mem_req_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            ir_we_q;
  logic            fault_q;
  logic [1:0]      cause_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            busy_q;

  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] eff_pc;
  logic            discard;
  logic            pc_inc;

  assign eff_pc  = redirect_valid ? redirect_pc : pc_cur;
  // A redirect in the same cycle as rvalid kills the response just like an earlier one.
  assign discard = kill_q | redirect_valid;
  assign pc_inc  = (state_q == WAIT) & mem_rvalid & ~mem_err & ~discard;

  fetch_pc_reg #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .CLK      (CLK),
    .RST      (RST),
    .load_i   (redirect_valid),
    .load_pc_i(redirect_pc),
    .inc_i    (pc_inc),
    .inc_pc_i (fetch_pc_q + XLEN'(INSTR_BYTES)),
    .pc_o     (pc_cur)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_we_q    <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
      instr_q    <= '0;
      instr_pc_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      ir_we_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetch_start) begin
            fetch_pc_q <= eff_pc;
            busy_q     <= 1'b1;
            if (eff_pc[1:0] != 2'b00) begin
              state_q <= RESP;
              fault_q <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
            end else begin
              state_q    <= REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= eff_pc;
            end
          end
        end
        REQ: begin
          if (redirect_valid) kill_q <= 1'b1;
          if (mem_gnt) begin
            state_q    <= WAIT;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        WAIT: begin
          if (redirect_valid) kill_q <= 1'b1;
          if (mem_rvalid) begin
            state_q <= RESP;
            if (!discard) begin
              if (mem_err) begin
                fault_q <= 1'b1;
                cause_q <= CAUSE_ACCESS;
              end else begin
                ir_we_q    <= 1'b1;
                instr_q    <= mem_rdata;
                instr_pc_q <= fetch_pc_q;
              end
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          kill_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign pc          = pc_cur;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign ir_we       = ir_we_q;
  assign fetch_busy  = busy_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetches push expected pulses,
// a negedge monitor pops and compares every ir_we / fetch_fault.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        fetch_start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  logic [31:0] pc, instr, instr_pc;
  logic        ir_we, fetch_busy, fetch_fault;
  logic [1:0]  fault_cause;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .fetch_start(fetch_start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .pc(pc), .instr(instr), .instr_pc(instr_pc), .ir_we(ir_we),
    .fetch_busy(fetch_busy), .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_fault;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] pc;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_we(input logic [31:0] ins, input logic [31:0] ipc, input logic [31:0] npc);
    exp_t e;
    e.is_fault = 1'b0; e.instr = ins; e.ipc = ipc; e.pc = npc; e.cause = 2'b00;
    sb.push_back(e);
  endtask

  task automatic push_fault(input logic [1:0] cause, input logic [31:0] npc);
    exp_t e;
    e.is_fault = 1'b1; e.instr = '0; e.ipc = '0; e.pc = npc; e.cause = cause;
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (ir_we && fetch_fault) chk("we_and_fault_exclusive", 32'd1, 32'd0);
    if (ir_we || fetch_fault) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, fetch_fault, ir_we}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, fetch_fault}, {31'd0, e.is_fault});
        chk("pc_at_pulse", pc, e.pc);
        if (e.is_fault) begin
          chk("fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
        end else begin
          chk("instr", instr, e.instr);
          chk("instr_pc", instr_pc, e.ipc);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Aligned fetch: gnt after gnt_dly idle REQ cycles, rvalid after rv_dly idle WAIT cycles.
  task automatic run_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           input logic err, input logic [31:0] exp_addr, input logic exp_pulse);
    fetch_start = 1'b1; step(); fetch_start = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge CLK);
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("addr_held", mem_addr, exp_addr);
      step();
    end
    mem_gnt = 1'b1;
    @(negedge CLK);
    chk("req_at_gnt", {31'd0, mem_req}, 32'd1);
    chk("addr_at_gnt", mem_addr, exp_addr);
    step(); mem_gnt = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge CLK);
      chk("req_dropped", {31'd0, mem_req}, 32'd0);
      chk("no_early_we", {31'd0, ir_we}, 32'd0);
      step();
    end
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    step(); mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    @(negedge CLK);
    chk("pulse_latency", {31'd0, ir_we | fetch_fault}, {31'd0, exp_pulse});
    step();
    @(negedge CLK);
    chk("idle_after_resp", {31'd0, fetch_busy}, 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ir_we", {31'd0, ir_we}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_cause", {30'd0, fault_cause}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    step();

    // 1: zero-wait fetch at 0
    push_we(32'h0050_0093, 32'h0, 32'h4);
    run_fetch(0, 0, 32'h0050_0093, 1'b0, 32'h0, 1'b1);
    chk("t1_pc", pc, 32'h4);

    // 2: gnt delayed 3, rvalid delayed 2
    push_we(32'h00A0_0113, 32'h4, 32'h8);
    run_fetch(3, 2, 32'h00A0_0113, 1'b0, 32'h4, 1'b1);
    chk("t2_pc", pc, 32'h8);

    // 3: redirect to a misaligned target with fetch_start
    push_fault(2'b01, 32'h102);
    redirect_valid = 1'b1; redirect_pc = 32'h102; fetch_start = 1'b1;
    step();
    redirect_valid = 1'b0; fetch_start = 1'b0;
    @(negedge CLK);
    chk("t3_no_req", {31'd0, mem_req}, 32'd0);
    chk("t3_busy", {31'd0, fetch_busy}, 32'd1);
    step();
    @(negedge CLK);
    chk("t3_pc", pc, 32'h102);
    chk("t3_no_req_after", {31'd0, mem_req}, 32'd0);
    step();

    // 4: access error at 0x40
    redirect_valid = 1'b1; redirect_pc = 32'h40; step(); redirect_valid = 1'b0;
    push_fault(2'b10, 32'h40);
    run_fetch(0, 0, 32'hDEAD_BEEF, 1'b1, 32'h40, 1'b1);
    chk("t4_pc", pc, 32'h40);
    chk("t4_cause_held", {30'd0, fault_cause}, 32'd2);

    // 5: redirect while in WAIT discards the response
    fetch_start = 1'b1; step(); fetch_start = 1'b0;
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200; step(); redirect_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; step(); mem_rvalid = 1'b0;
    @(negedge CLK);
    chk("t5_no_we", {31'd0, ir_we}, 32'd0);
    chk("t5_no_fault", {31'd0, fetch_fault}, 32'd0);
    step();
    chk("t5_pc", pc, 32'h200);
    push_we(32'h0000_0013, 32'h200, 32'h204);
    run_fetch(1, 0, 32'h0000_0013, 1'b0, 32'h200, 1'b1);
    chk("t5_pc_after", pc, 32'h204);

    // 6: reset in WAIT, late rvalid ignored, then wrap fetch
    fetch_start = 1'b1; step(); fetch_start = 1'b0;
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    RST = 1'b1; #2;
    chk("t6_rst_req", {31'd0, mem_req}, 32'd0);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("t6_rst_cause", {30'd0, fault_cause}, 32'd0);
    step(); RST = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; step(); mem_rvalid = 1'b0;
    @(negedge CLK);
    chk("t6_late_no_we", {31'd0, ir_we}, 32'd0);
    step();
    @(negedge CLK);
    chk("t6_pc_idle", pc, 32'h0);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; step(); redirect_valid = 1'b0;
    push_we(32'h0000_006F, 32'hFFFF_FFFC, 32'h0);
    run_fetch(0, 1, 32'h0000_006F, 1'b0, 32'hFFFF_FFFC, 1'b1);
    chk("t6_wrap_pc", pc, 32'h0);

    step(); step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch controller for the multicycle RV32 core. It owns the architectural PC and, when the control FSM requests a fetch, runs a req/gnt/rvalid read on the instruction memory port. It then presents the fetched word and its PC, with a one-cycle write-enable that loads the downstream IR and OldPC clock-enabled registers. It also handles PC redirects from writeback, misaligned-PC faults and memory access faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address/data width (only 32 supported).

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
fetch_start  in  1  control FSM request to fetch at current pc.
redirect_valid  in  1  load redirect_pc into pc.
redirect_pc  in  32  new PC (branch/jump/trap target).
mem_req  out  1  instruction memory read request.
mem_addr  out  32  read address (word aligned).
mem_gnt  in  1  request accepted.
mem_rvalid  in  1  read data valid.
mem_rdata  in  32  read data.
mem_err  in  1  access error, qualified by mem_rvalid.
pc  out  32  current architectural PC.
instr  out  32  fetched instruction.
instr_pc  out  32  PC of instr.
ir_we  out  1  one-cycle pulse: instr/instr_pc valid; CE for IR/OldPC.
fetch_busy  out  1  high in REQ, WAIT, RESP.
fetch_fault  out  1  one-cycle fault pulse (replaces ir_we).
fault_cause  out  2  01 misaligned, 10 access error; valid with fetch_fault, held until next fault.

Behaviour:
- Reset: one clock with asynchronous active-high reset. Outputs are asynchronously forced: state=IDLE, pc=RESET_PC, mem_req=0, ir_we=0, fetch_fault=0, fault_cause=0, instr=0, instr_pc=0, kill=0. Reset mid-transaction abandons it. rvalid arriving after reset is ignored in IDLE.
- All outputs are registered. mem_addr equals pc in REQ and 0 otherwise.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - redirect_valid: pc<=redirect_pc.
  - fetch_start: the effective PC is redirect_pc if redirect_valid in the same cycle, else pc.
  - If effective PC[1:0]!=0: go to RESP with fault pending (cause 01); no memory access.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1, mem_addr stable until mem_gnt.
  - mem_gnt: go to WAIT; mem_req drops the next cycle.
  - The request is never withdrawn.
- WAIT:
  - Wait for mem_rvalid; the memory guarantees rvalid at least one cycle after gnt.
  - On rvalid, capture rdata/err and go to RESP.
- RESP (one cycle):
  - Normal: ir_we=1, instr=captured data, instr_pc=fetch PC, pc<=fetch PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
  - mem_err: fetch_fault=1, cause=10, pc unchanged, no ir_we.
  - Misaligned: fetch_fault=1, cause=01, pc unchanged.
  - Then return to IDLE.
- Total latency from fetch_start to ir_we = 1 (REQ) + gnt wait + 1 (WAIT min) + rvalid wait + 1, i.e. 3 cycles minimum.
- fetch_start while busy is ignored (no queueing).
- redirect_valid while busy:
  - Sets kill and pc<=redirect_pc.
  - The in-flight transaction still completes on the bus, but the response is discarded: no ir_we, no fault, pc not incremented.
  - kill clears on return to IDLE.
  - A later redirect while busy overwrites pc again.
- ir_we and fetch_fault are never high together; each is high for exactly one cycle per fetch_start.

Decomposition:
- Package fetch_pkg: state enum (IDLE, REQ, WAIT, RESP), fault cause constants (CAUSE_NONE=00, CAUSE_MISALIGN=01, CAUSE_ACCESS=10), INSTR_BYTES=4.
- One natural sub-module: fetch_pc_reg, the 32-bit PC register with asynchronous reset to RESET_PC and priority load (redirect > increment > hold).
- The FSM and capture registers stay in fetch_unit.

Test Plan:
1. Reset, then fetch_start with gnt the same cycle as req and rvalid the next cycle, rdata=32'h00500093 -> mem_addr=0; ir_we pulses 3 cycles after start; instr=32'h00500093, instr_pc=0, pc=4.
2. gnt delayed 3 cycles, rvalid delayed 2 more -> mem_req/mem_addr stable for 4 cycles; single ir_we; pc advances 4 exactly once.
3. Redirect_valid=1 with redirect_pc=32'h0000_0102 and fetch_start in IDLE -> no mem_req; fetch_fault pulse, cause=01; pc=32'h0000_0102.
4. rvalid with mem_err=1 at pc=32'h0000_0040 -> fetch_fault pulse, cause=10, no ir_we, pc stays 32'h40.
5. redirect_valid (pc 32'h0000_0200) in WAIT -> response discarded, no ir_we/fault; pc=32'h200. Next fetch_start uses mem_addr=32'h200.
6. Assert RST while in WAIT, then deliver rvalid after release -> mem_req=0 immediately, pc=RESET_PC, late rvalid produces no ir_we; pc=32'hFFFF_FFFC fetch wraps pc to 0.
